// File: rtl/rob_multi.sv
// Multi-retire reorder buffer: in-order allocation (one per cycle), several
// out-of-order completion ports, up to RET_WIDTH in-order retirements per
// cycle, and a full flush. count is the pointer distance tail - head, which
// uses the wrap bit to tell full (DEPTH) from empty (0).
//
// Alloc handshake: an entry is taken on a rising edge where
// alloc_valid && alloc_ready. alloc_ready depends only on registered state
// (never on alloc_valid). alloc_valid with alloc_ready low is simply ignored.
module rob_multi #(
  parameter int DEPTH     = 16,
  parameter int PREG_W    = 6,
  parameter int PC_W      = 32,
  parameter int CPL_PORTS = 2,
  parameter int RET_WIDTH = 2,
  localparam int TAG_W    = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic [PREG_W-1:0]             alloc_rd,
  input  logic [PREG_W-1:0]             alloc_rd_old,
  input  logic [PC_W-1:0]               alloc_pc,
  output logic [TAG_W-1:0]              alloc_tag,
  input  logic [CPL_PORTS-1:0]          cpl_valid,
  input  logic [CPL_PORTS*TAG_W-1:0]    cpl_tag,
  input  logic                          flush,
  output logic [RET_WIDTH-1:0]          ret_valid,
  output logic [RET_WIDTH*PREG_W-1:0]   ret_rd,
  output logic [RET_WIDTH*PREG_W-1:0]   ret_rd_old,
  output logic [RET_WIDTH*PC_W-1:0]     ret_pc,
  output logic [TAG_W:0]                count,
  output logic                          empty,
  output logic                          full
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] CNT_ONE  = (TAG_W+1)'(1);

  // Pointers carry a wrap bit above the array index.
  logic [TAG_W:0]       head;
  logic [TAG_W:0]       tail;
  logic [TAG_W-1:0]     tail_idx;

  // Per-entry status bits and payload.
  logic [DEPTH-1:0]     valid;
  logic [DEPTH-1:0]     comp;
  logic [PREG_W-1:0]    rd_mem     [DEPTH];
  logic [PREG_W-1:0]    rd_old_mem [DEPTH];
  logic [PC_W-1:0]      pc_mem     [DEPTH];

  // Per-cycle update masks and retire selection.
  logic                 alloc_fire;
  logic [DEPTH-1:0]     alloc_set;
  logic [DEPTH-1:0]     cpl_set;
  logic [DEPTH-1:0]     ret_clr;
  logic [RET_WIDTH-1:0] ret_take;
  logic [TAG_W-1:0]     ret_idx [RET_WIDTH];
  logic [TAG_W:0]       ret_n;
  logic                 ret_run;

  assign tail_idx    = tail[TAG_W-1:0];
  assign alloc_tag   = tail_idx;
  assign count       = tail - head;
  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign alloc_ready = !full;
  assign alloc_fire  = alloc_valid && alloc_ready;

  // One-hot mask of the entry being allocated this cycle.
  always_comb begin
    alloc_set = '0;
    if (alloc_fire) alloc_set[tail_idx] = 1'b1;
  end

  // Completions only mark entries that are already valid; duplicate tags merge.
  always_comb begin
    cpl_set = '0;
    for (int k = 0; k < CPL_PORTS; k++) begin
      if (cpl_valid[k] && valid[cpl_tag[k*TAG_W +: TAG_W]])
        cpl_set[cpl_tag[k*TAG_W +: TAG_W]] = 1'b1;
    end
  end

  // Retire the longest run of valid+complete entries from head, capped at RET_WIDTH.
  always_comb begin
    ret_n    = '0;
    ret_run  = 1'b1;
    ret_take = '0;
    ret_clr  = '0;
    for (int i = 0; i < RET_WIDTH; i++) begin
      ret_idx[i]  = head[TAG_W-1:0] + TAG_W'(i);
      ret_run     = ret_run && valid[ret_idx[i]] && comp[ret_idx[i]];
      ret_take[i] = ret_run;
      if (ret_run) begin
        ret_n               = ret_n + CNT_ONE;
        ret_clr[ret_idx[i]] = 1'b1;
      end
    end
  end

  // Pointers, status bits and registered retire outputs; flush overrides all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      valid      <= '0;
      comp       <= '0;
      ret_valid  <= '0;
      ret_rd     <= '0;
      ret_rd_old <= '0;
      ret_pc     <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      valid     <= '0;
      comp      <= '0;
      ret_valid <= '0;
    end else begin
      head      <= head + ret_n;
      tail      <= tail + (TAG_W+1)'(alloc_fire);
      valid     <= (valid & ~ret_clr) | alloc_set;
      comp      <= (comp | cpl_set) & ~ret_clr & ~alloc_set;
      ret_valid <= ret_take;
      for (int i = 0; i < RET_WIDTH; i++) begin
        ret_rd[i*PREG_W +: PREG_W]     <= rd_mem[ret_idx[i]];
        ret_rd_old[i*PREG_W +: PREG_W] <= rd_old_mem[ret_idx[i]];
        ret_pc[i*PC_W +: PC_W]         <= pc_mem[ret_idx[i]];
      end
    end
  end

  // Entry payload is written on allocation and needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire && !flush) begin
      rd_mem[tail_idx]     <= alloc_rd;
      rd_old_mem[tail_idx] <= alloc_rd_old;
      pc_mem[tail_idx]     <= alloc_pc;
    end
  end

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi (DEPTH=16, two completion ports, retire width 2).
module tb_rob_multi;

  localparam int DEPTH     = 16;
  localparam int PREG_W    = 6;
  localparam int PC_W      = 32;
  localparam int CPL_PORTS = 2;
  localparam int RET_WIDTH = 2;
  localparam int TAG_W     = 4;
  localparam int SB_W      = 2*PREG_W + PC_W;

  logic                        clk;
  logic                        rst;
  logic                        alloc_valid;
  logic                        alloc_ready;
  logic [PREG_W-1:0]           alloc_rd;
  logic [PREG_W-1:0]           alloc_rd_old;
  logic [PC_W-1:0]             alloc_pc;
  logic [TAG_W-1:0]            alloc_tag;
  logic [CPL_PORTS-1:0]        cpl_valid;
  logic [CPL_PORTS*TAG_W-1:0]  cpl_tag;
  logic                        flush;
  logic [RET_WIDTH-1:0]        ret_valid;
  logic [RET_WIDTH*PREG_W-1:0] ret_rd;
  logic [RET_WIDTH*PREG_W-1:0] ret_rd_old;
  logic [RET_WIDTH*PC_W-1:0]   ret_pc;
  logic [TAG_W:0]              count;
  logic                        empty;
  logic                        full;

  rob_multi #(
    .DEPTH(DEPTH), .PREG_W(PREG_W), .PC_W(PC_W),
    .CPL_PORTS(CPL_PORTS), .RET_WIDTH(RET_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_rd(alloc_rd), .alloc_rd_old(alloc_rd_old), .alloc_pc(alloc_pc),
    .alloc_tag(alloc_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .flush(flush),
    .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_rd_old(ret_rd_old), .ret_pc(ret_pc),
    .count(count), .empty(empty), .full(full)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One vector = inputs held for one cycle, expectations sampled after the edge.
  typedef struct {
    logic       r;
    logic       f;
    logic       a;
    logic [1:0] cv;
    logic [3:0] t0;
    logic [3:0] t1;
    logic [4:0] e_cnt;
    logic [3:0] e_tag;
    logic [1:0] e_ret;
  } vec_t;

  vec_t            vecs[$];
  logic [SB_W-1:0] exp_q[$];
  int              n_vec;
  int              n_fail;
  int              seq;
  int              model_cnt;

  function automatic vec_t mk(input logic r, input logic f, input logic a,
                              input logic [1:0] cv, input logic [3:0] t0,
                              input logic [3:0] t1, input logic [4:0] e_cnt,
                              input logic [3:0] e_tag, input logic [1:0] e_ret);
    vec_t v;
    v = '{r, f, a, cv, t0, t1, e_cnt, e_tag, e_ret};
    return v;
  endfunction

  function automatic void add(input logic r, input logic f, input logic a,
                              input logic [1:0] cv, input logic [3:0] t0,
                              input logic [3:0] t1, input logic [4:0] e_cnt,
                              input logic [3:0] e_tag, input logic [1:0] e_ret);
    vecs.push_back(mk(r, f, a, cv, t0, t1, e_cnt, e_tag, e_ret));
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Check the occupancy-derived outputs against an expected count and tag.
  task automatic chk_state(input string name, input logic [4:0] e_cnt,
                           input logic [3:0] e_tag, input logic [1:0] e_ret);
    chk({name, " count"},       64'(count),       64'(e_cnt));
    chk({name, " alloc_tag"},   64'(alloc_tag),   64'(e_tag));
    chk({name, " ret_valid"},   64'(ret_valid),   64'(e_ret));
    chk({name, " full"},        64'(full),        64'(e_cnt == 5'd16));
    chk({name, " empty"},       64'(empty),       64'(e_cnt == 5'd0));
    chk({name, " alloc_ready"}, 64'(alloc_ready), 64'(e_cnt != 5'd16));
  endtask

  // Driver: apply one vector, then check outputs and retired payloads.
  task automatic apply_vec(input vec_t v, input string name);
    logic [SB_W-1:0] want;
    logic [SB_W-1:0] got;
    @(negedge clk);
    if (v.r) rst = 1'b1;
    flush        = v.f;
    alloc_valid  = v.a;
    alloc_rd     = 6'(seq);
    alloc_rd_old = ~6'(seq);
    alloc_pc     = 32'h4000_0000 + 32'(seq) * 32'd4;
    cpl_valid    = v.cv;
    cpl_tag      = {v.t1, v.t0};
    if (v.a && !v.f && !v.r && model_cnt < DEPTH)
      exp_q.push_back({alloc_rd, alloc_rd_old, alloc_pc});
    if (v.a) seq++;
    @(posedge clk);
    #1;
    chk_state(name, v.e_cnt, v.e_tag, v.e_ret);
    for (int i = 0; i < RET_WIDTH; i++) begin
      if (v.e_ret[i]) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL %s ret slot%0d: got a retirement, expected none queued", name, i);
        end else begin
          want = exp_q.pop_front();
          got  = {ret_rd[i*PREG_W +: PREG_W], ret_rd_old[i*PREG_W +: PREG_W],
                  ret_pc[i*PC_W +: PC_W]};
          chk($sformatf("%s ret slot%0d data", name, i), 64'(got), 64'(want));
        end
      end
    end
    if (v.r || v.f) exp_q.delete();
    model_cnt   = int'(v.e_cnt);
    rst         = 1'b0;
    flush       = 1'b0;
    alloc_valid = 1'b0;
    cpl_valid   = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0;
    alloc_rd = '0; alloc_rd_old = '0; alloc_pc = '0;
    cpl_valid = '0; cpl_tag = '0;
    n_vec = 0; n_fail = 0; seq = 0; model_cnt = 0;

    // Reset and fill: tags 0..15, then a 17th request is refused.
    add(1, 0, 0, 2'b00, 4'd0, 4'd0, 5'd0, 4'd0, 2'b00);
    for (int i = 0; i < 16; i++)
      add(0, 0, 1, 2'b00, 4'd0, 4'd0, 5'(i + 1), 4'((i + 1) % 16), 2'b00);
    add(0, 0, 1, 2'b00, 4'd0, 4'd0, 5'd16, 4'd0, 2'b00);
    // Drain: two completions per cycle, retirement trails by one edge.
    for (int c = 0; c < 8; c++)
      add(0, 0, 0, 2'b11, 4'(2*c), 4'(2*c + 1), 5'(c == 0 ? 16 : 16 - 2*c), 4'd0,
          (c == 0) ? 2'b00 : 2'b11);
    add(0, 0, 0, 2'b00, 4'd0, 4'd0, 5'd0, 4'd0, 2'b11);
    add(0, 0, 0, 2'b00, 4'd0, 4'd0, 5'd0, 4'd0, 2'b00);

    // Out-of-order completion: tags 0..3 complete 3,2,1,0; then 2+2 retire (width cap).
    for (int i = 0; i < 4; i++)
      add(0, 0, 1, 2'b00, 4'd0, 4'd0, 5'(i + 1), 4'(i + 1), 2'b00);
    add(0, 0, 0, 2'b01, 4'd3, 4'd0, 5'd4, 4'd4, 2'b00);
    add(0, 0, 0, 2'b01, 4'd2, 4'd0, 5'd4, 4'd4, 2'b00);
    add(0, 0, 0, 2'b01, 4'd1, 4'd0, 5'd4, 4'd4, 2'b00);
    add(0, 0, 0, 2'b01, 4'd0, 4'd0, 5'd4, 4'd4, 2'b00);
    add(0, 0, 0, 2'b00, 4'd0, 4'd0, 5'd2, 4'd4, 2'b11);
    add(0, 0, 0, 2'b00, 4'd0, 4'd0, 5'd0, 4'd4, 2'b11);
    add(0, 0, 0, 2'b00, 4'd0, 4'd0, 5'd0, 4'd4, 2'b00);

    // Dual completion: five entries (tags 4..8), count 5 -> 3 -> 1 -> 0.
    for (int i = 0; i < 5; i++)
      add(0, 0, 1, 2'b00, 4'd0, 4'd0, 5'(i + 1), 4'(5 + i), 2'b00);
    add(0, 0, 0, 2'b11, 4'd4, 4'd5, 5'd5, 4'd9, 2'b00);
    add(0, 0, 0, 2'b11, 4'd6, 4'd7, 5'd3, 4'd9, 2'b11);
    add(0, 0, 0, 2'b11, 4'd8, 4'd8, 5'd1, 4'd9, 2'b11);
    add(0, 0, 0, 2'b01, 4'd12, 4'd0, 5'd0, 4'd9, 2'b01);
    add(0, 0, 0, 2'b00, 4'd0, 4'd0, 5'd0, 4'd9, 2'b00);

    // Wrap-around: reset, stream 14 entries through (one retire per cycle).
    add(1, 0, 0, 2'b00, 4'd0, 4'd0, 5'd0, 4'd0, 2'b00);
    for (int c = 0; c < 16; c++)
      add(0, 0, c < 14, (c >= 1 && c <= 14) ? 2'b01 : 2'b00, 4'(c - 1), 4'd0,
          5'((c < 14 ? c + 1 : 14) - (c >= 2 ? c - 1 : 0)),
          4'(c < 14 ? c + 1 : 14), (c >= 2) ? 2'b01 : 2'b00);
    add(0, 0, 0, 2'b00, 4'd0, 4'd0, 5'd0, 4'd14, 2'b00);
    // Tags 14,15,0,1; a completion aimed at the tag being allocated is ignored.
    for (int c = 0; c < 4; c++)
      add(0, 0, 1, 2'b10, 4'd0, 4'((14 + c) % 16), 5'(c + 1), 4'((15 + c) % 16), 2'b00);
    add(0, 0, 0, 2'b11, 4'd14, 4'd15, 5'd4, 4'd2, 2'b00);
    add(0, 0, 0, 2'b11, 4'd0, 4'd1, 5'd2, 4'd2, 2'b11);
    add(0, 0, 0, 2'b00, 4'd0, 4'd0, 5'd0, 4'd2, 2'b11);

    // Flush: occupancy 7 (tags 2..8), head completed, flush with alloc+completion.
    for (int i = 0; i < 7; i++)
      add(0, 0, 1, 2'b00, 4'd0, 4'd0, 5'(i + 1), 4'(3 + i), 2'b00);
    add(0, 0, 0, 2'b01, 4'd2, 4'd0, 5'd7, 4'd9, 2'b00);
    add(0, 1, 1, 2'b01, 4'd3, 4'd0, 5'd0, 4'd0, 2'b00);
    add(0, 0, 0, 2'b01, 4'd3, 4'd0, 5'd0, 4'd0, 2'b00);
    add(0, 0, 0, 2'b00, 4'd0, 4'd0, 5'd0, 4'd0, 2'b00);

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++)
      apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Async reset mid-operation: six entries, tags 0 and 1 completed at the last
    // edge so they would retire at the next one; reset lands between the edges.
    for (int i = 0; i < 6; i++)
      apply_vec(mk(0, 0, 1, 2'b00, 4'd0, 4'd0, 5'(i + 1), 4'(i + 1), 2'b00),
                $sformatf("arst_fill%0d", i));
    apply_vec(mk(0, 0, 0, 2'b11, 4'd0, 4'd1, 5'd6, 4'd6, 2'b00), "arst_cpl");
    #2;
    rst = 1'b1;
    #1;
    chk_state("arst_immediate", 5'd0, 4'd0, 2'b00);
    exp_q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    apply_vec(mk(0, 0, 0, 2'b00, 4'd0, 4'd0, 5'd0, 4'd0, 2'b00), "arst_after0");
    apply_vec(mk(0, 0, 0, 2'b01, 4'd1, 4'd0, 5'd0, 4'd0, 2'b00), "arst_after1");
    apply_vec(mk(0, 0, 0, 2'b00, 4'd0, 4'd0, 5'd0, 4'd0, 2'b00), "arst_after2");

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
